traffic_phase_ctrl: RTL
=======================

Name: traffic_phase_ctrl

Overview:
- Phase sequencer for a two-approach intersection (NS/EW), with pedestrian-walk insertion and emergency pre-emption.
- Owns no counter of its own. Each phase dwell is timed by driving an external `timer` instance (start/load_val in, running/done back), through a registered start pulse.
- Drives the lamp outputs and a phase code for status/debug.

Parameters:
- WIDTH, 16, width of timer load values and cfg_* inputs.
- PHASE_W, 4, width of the phase status code.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- enable  in  1  1 = normal sequencing; 0 = hold ALL_RED
- ped_req  in  1  pedestrian button, single-cycle or level; latched
- emg_req  in  1  emergency pre-emption request, level
- emg_dir  in  1  emergency direction, 0 = NS, 1 = EW; sampled on pre-emption entry
- cfg_green_ns  in  WIDTH  NS green timer load
- cfg_green_ew  in  WIDTH  EW green timer load
- cfg_yellow  in  WIDTH  yellow timer load
- cfg_allred  in  WIDTH  all-red clearance timer load
- cfg_walk  in  WIDTH  pedestrian walk timer load
- timer_done  in  1  from timer, 1-cycle pulse
- timer_running  in  1  from timer (status only, not used for transitions)
- timer_start  out  1  to timer, 1-cycle registered pulse
- timer_load  out  WIDTH  to timer load_val, registered, valid while timer_start=1
- ns_light  out  3  {red,yellow,green} one-hot
- ew_light  out  3  {red,yellow,green} one-hot
- walk  out  1  pedestrian walk lamp
- ped_pending  out  1  latched pedestrian request
- phase  out  PHASE_W  current state code

Behaviour:
- Reset is asynchronous, active-high; clk is the clock. Reset values:
  - state = IDLE_RED
  - ns_light = ew_light = 3'b100
  - walk = 0
  - timer_start = 0, timer_load = 0
  - ped_pending = 0
- All outputs are registered; lamps are decoded from the next state so they change on the same edge as the state.
- States:
  - IDLE_RED
  - ALLRED_A
  - NS_GREEN
  - NS_YELLOW
  - ALLRED_B
  - EW_GREEN
  - EW_YELLOW
  - ALLRED_C
  - PED_WALK
  - EMG_CLEAR
  - EMG_GREEN
- Timer dwell rule:
  - On every state entry (except into IDLE_RED and EMG_GREEN), timer_start=1 for exactly the entry cycle, with timer_load = that state's cfg value.
  - The state leaves on the first cycle timer_done=1, excluding the entry cycle.
  - Resulting dwell = load + 3 cycles.
  - timer_done seen in the entry cycle is stale and is ignored.
- Normal cycle: ALLRED_A → NS_GREEN → NS_YELLOW → ALLRED_B → EW_GREEN → EW_YELLOW → ALLRED_C → (PED_WALK if ped_pending) → ALLRED_A.
- PED_WALK: all lamps red, walk=1. ped_pending clears on PED_WALK entry. A ped_req arriving during PED_WALK re-latches and is served next cycle round.
- ped_pending sets on ped_req in any state and holds until served. Reset clears it.
- Pre-emption:
  - Trigger: emg_req=1 in NS_GREEN/EW_GREEN of the direction not matching emg_dir. Action: abort to that direction's YELLOW immediately, with a new timer_start (the timer reload overrides its running count).
  - Trigger: emg_req=1 in any other normal state. Action: finish the current dwell, then go to EMG_CLEAR (all red, cfg_allred) instead of the normal successor.
  - After a yellow reached this way, the next state is EMG_CLEAR.
  - EMG_CLEAR → EMG_GREEN. emg_dir is latched on EMG_CLEAR entry.
  - EMG_GREEN: latched direction green, other direction red, no timer. Held while emg_req=1.
  - When emg_req drops in EMG_GREEN, go to the matching yellow (NS_YELLOW or EW_YELLOW), then resume the normal cycle from there.
  - If emg_req drops during EMG_CLEAR, EMG_GREEN is still entered and exits on the next cycle.
- enable=0:
  - Any state goes to IDLE_RED next cycle; no timer_start is issued.
  - Exception: from a green the block first passes through the matching yellow, then IDLE_RED.
  - enable 0→1 in IDLE_RED enters ALLRED_A.
  - emg_req is honoured only when enable=1.
- Simultaneous events:
  - emg_req beats ped service.
  - timer_done and an abort in the same cycle: the abort wins.
- Safety invariant: ns_light and ew_light are never both non-red. walk=1 only in PED_WALK.
- Reset mid-operation returns to IDLE_RED. The timer is reset by the same reset.

Decomposition:
- Shared package `smartflow_pkg`:
  - state enum and phase codes
  - lamp encodings LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001
- Sub-module `phase_lamp_decode`: combinational state → {ns_light, ew_light, walk}.
- The timer instance stays outside this block; a top level wires the two together.

Test Plan:
- Full cycle with loads green=5, yellow=2, allred=1, timer attached, no requests → dwells NS_GREEN 8, NS_YELLOW 5, ALLRED 4 cycles; exactly one timer_start per state entry; lamps never conflict.
- ped_req pulse during NS_GREEN, cfg_walk=4 → ped_pending=1 until PED_WALK entry after ALLRED_C; walk=1 for 7 cycles; then ALLRED_A.
- emg_req=1, emg_dir=1 mid NS_GREEN → next state NS_YELLOW with timer_start, load=2; then EMG_CLEAR, then EMG_GREEN with ew_light=GRN held 20 cycles; drop emg_req → EW_YELLOW → ALLRED_C.
- enable=0 during EW_GREEN → EW_YELLOW, then IDLE_RED with both red and no further timer_start; enable=1 → ALLRED_A with timer_start.
- Stale done: inject timer_done on the entry cycle of NS_YELLOW → ignored, state holds.
- reset asserted in EW_YELLOW → all outputs at reset values immediately; after release, IDLE_RED → ALLRED_A.

Source files
------------

// File: rtl/smartflow_pkg.sv
// Shared types and constants for the intersection phase sequencer.
// State encodings double as the phase status code.
package smartflow_pkg;

    typedef enum logic [3:0] {
        IDLE_RED  = 4'd0,
        ALLRED_A  = 4'd1,
        NS_GREEN  = 4'd2,
        NS_YELLOW = 4'd3,
        ALLRED_B  = 4'd4,
        EW_GREEN  = 4'd5,
        EW_YELLOW = 4'd6,
        ALLRED_C  = 4'd7,
        PED_WALK  = 4'd8,
        EMG_CLEAR = 4'd9,
        EMG_GREEN = 4'd10
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // IDLE_RED and EMG_GREEN are held by inputs, not by a timed dwell.
    function automatic logic needs_timer(input state_t s);
        return (s != IDLE_RED) && (s != EMG_GREEN);
    endfunction

    // States of the regular rotation, where an emergency request is remembered.
    function automatic logic is_normal(input state_t s);
        return (s >= ALLRED_A) && (s <= PED_WALK);
    endfunction

endpackage

// File: rtl/phase_lamp_decode.sv
// Combinational decode of a sequencer state into lamp and walk outputs.
module phase_lamp_decode
    import smartflow_pkg::*;
(
    input  logic [3:0] state,
    input  logic       emg_dir,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk
);

    state_t s;
    assign s = state_t'(state);

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        walk     = 1'b0;
        case (s)
            NS_GREEN:  ns_light = LAMP_GRN;
            NS_YELLOW: ns_light = LAMP_YEL;
            EW_GREEN:  ew_light = LAMP_GRN;
            EW_YELLOW: ew_light = LAMP_YEL;
            PED_WALK:  walk     = 1'b1;
            EMG_GREEN: begin
                if (emg_dir) ew_light = LAMP_GRN;
                else         ns_light = LAMP_GRN;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-approach intersection phase sequencer with pedestrian walk and
// emergency pre-emption; dwells are timed by an external timer.
module traffic_phase_ctrl
    import smartflow_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PHASE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               ped_req,
    input  logic               emg_req,
    input  logic               emg_dir,
    input  logic [WIDTH-1:0]   cfg_green_ns,
    input  logic [WIDTH-1:0]   cfg_green_ew,
    input  logic [WIDTH-1:0]   cfg_yellow,
    input  logic [WIDTH-1:0]   cfg_allred,
    input  logic [WIDTH-1:0]   cfg_walk,
    input  logic               timer_done,
    input  logic               timer_running,
    output logic               timer_start,
    output logic [WIDTH-1:0]   timer_load,
    output logic [2:0]         ns_light,
    output logic [2:0]         ew_light,
    output logic               walk,
    output logic               ped_pending,
    output logic [PHASE_W-1:0] phase
);

    state_t           state, state_nxt;
    logic             emg_flag, emg_dir_q, dir_nxt;
    logic             done_eff, emg_any, start_nxt;
    logic [WIDTH-1:0] load_nxt;
    logic [2:0]       ns_dec, ew_dec;
    logic             walk_dec;
    logic             unused_timer_running;

    assign unused_timer_running = timer_running;

    // A done arriving while our start pulse is still out belongs to the old dwell.
    assign done_eff = timer_done && !timer_start;
    assign emg_any  = emg_req || emg_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE_RED;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            case (state)
                NS_GREEN:  state_nxt = NS_YELLOW;
                EW_GREEN:  state_nxt = EW_YELLOW;
                EMG_GREEN: state_nxt = emg_dir_q ? EW_YELLOW : NS_YELLOW;
                NS_YELLOW, EW_YELLOW: if (done_eff) state_nxt = IDLE_RED;
                default:   state_nxt = IDLE_RED;
            endcase
        end else begin
            case (state)
                IDLE_RED:  state_nxt = ALLRED_A;
                ALLRED_A:  if (done_eff) state_nxt = emg_any ? EMG_CLEAR : NS_GREEN;
                NS_GREEN: begin
                    if (emg_req && emg_dir) state_nxt = NS_YELLOW;
                    else if (done_eff)      state_nxt = NS_YELLOW;
                end
                NS_YELLOW: if (done_eff) state_nxt = emg_any ? EMG_CLEAR : ALLRED_B;
                ALLRED_B:  if (done_eff) state_nxt = emg_any ? EMG_CLEAR : EW_GREEN;
                EW_GREEN: begin
                    if (emg_req && !emg_dir) state_nxt = EW_YELLOW;
                    else if (done_eff)       state_nxt = EW_YELLOW;
                end
                EW_YELLOW: if (done_eff) state_nxt = emg_any ? EMG_CLEAR : ALLRED_C;
                ALLRED_C: begin
                    if (done_eff) begin
                        if (emg_any)          state_nxt = EMG_CLEAR;
                        else if (ped_pending) state_nxt = PED_WALK;
                        else                  state_nxt = ALLRED_A;
                    end
                end
                PED_WALK:  if (done_eff) state_nxt = emg_any ? EMG_CLEAR : ALLRED_A;
                EMG_CLEAR: if (done_eff) state_nxt = EMG_GREEN;
                EMG_GREEN: if (!emg_req) state_nxt = emg_dir_q ? EW_YELLOW : NS_YELLOW;
                default:   state_nxt = IDLE_RED;
            endcase
        end
    end

    // Remembers a request seen mid-dwell (or an abort) so the dwell end diverts
    // to EMG_CLEAR even if emg_req has since dropped; a green finishing its
    // dwell still passes through its yellow first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   emg_flag <= 1'b0;
        else if (!enable || state_nxt == EMG_CLEAR)  emg_flag <= 1'b0;
        else if (emg_req && is_normal(state))        emg_flag <= 1'b1;
    end

    assign dir_nxt = (state_nxt == EMG_CLEAR && state != EMG_CLEAR) ? emg_dir : emg_dir_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) emg_dir_q <= 1'b0;
        else       emg_dir_q <= dir_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          ped_pending <= 1'b0;
        else if (state_nxt == PED_WALK && state != PED_WALK) ped_pending <= 1'b0;
        else if (ped_req)                                   ped_pending <= 1'b1;
    end

    assign start_nxt = (state_nxt != state) && needs_timer(state_nxt);

    always_comb begin
        load_nxt = '0;
        case (state_nxt)
            ALLRED_A, ALLRED_B, ALLRED_C, EMG_CLEAR: load_nxt = cfg_allred;
            NS_GREEN:             load_nxt = cfg_green_ns;
            EW_GREEN:             load_nxt = cfg_green_ew;
            NS_YELLOW, EW_YELLOW: load_nxt = cfg_yellow;
            PED_WALK:             load_nxt = cfg_walk;
            default:              load_nxt = '0;
        endcase
    end

    phase_lamp_decode u_decode (
        .state    (state_nxt),
        .emg_dir  (dir_nxt),
        .ns_light (ns_dec),
        .ew_light (ew_dec),
        .walk     (walk_dec)
    );

    // Lamps and timer command are registered from the next state so they
    // change on the same edge as the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ns_light    <= LAMP_RED;
            ew_light    <= LAMP_RED;
            walk        <= 1'b0;
            timer_start <= 1'b0;
            timer_load  <= '0;
        end else begin
            ns_light    <= ns_dec;
            ew_light    <= ew_dec;
            walk        <= walk_dec;
            timer_start <= start_nxt;
            timer_load  <= start_nxt ? load_nxt : '0;
        end
    end

    assign phase = PHASE_W'(state);

endmodule
